// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable frame format, majority-of-3 mid-bit sampling,
// parity/framing/break detection and a valid/ready holding register with overrun flag.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic                 i_Rx,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int H  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_A    = CW'(H - 1);
    localparam logic [CW-1:0] CNT_B    = CW'(H);
    localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                 rx_meta, rx;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 ferr_q, ferr_d;
    logic                 zero_q, zero_d;
    logic                 samp_a_q, samp_a_d;
    logic                 samp_b_q, samp_b_d;
    logic                 maj, at_dec, at_wrap;
    logic                 load, load_brk, load_ferr, par_err;

    assign maj     = (samp_a_q & samp_b_q) | (samp_a_q & rx) | (samp_b_q & rx);
    assign at_dec  = (cnt_q == CNT_DEC);
    assign at_wrap = (cnt_q == CNT_LAST);

    always_comb begin
        par_err = 1'b0;
        if (PARITY == 1) begin
            par_err = ~(^shift_q ^ par_q);
        end else if (PARITY == 2) begin
            par_err = ^shift_q ^ par_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        par_d     = par_q;
        ferr_d    = ferr_q;
        zero_d    = zero_q;
        samp_a_d  = samp_a_q;
        samp_b_d  = samp_b_q;
        load      = 1'b0;
        load_brk  = 1'b0;
        load_ferr = 1'b0;

        if (state_q != S_IDLE && state_q != S_BREAK) begin
            cnt_d = at_wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_A) samp_a_d = rx;
            if (cnt_q == CNT_B) samp_b_d = rx;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx) begin
                    state_d = S_START;
                    zero_d  = 1'b1;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (at_dec && maj) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (at_wrap) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (at_dec) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    zero_d  = zero_q & ~maj;
                end
                if (at_wrap) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_d  = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (at_dec) begin
                    par_d  = maj;
                    zero_d = zero_q & ~maj;
                end
                if (at_wrap) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (at_dec) begin
                    ferr_d = ferr_q | ~maj;
                    zero_d = zero_q & ~maj;
                    // Last stop bit: deliver at mid-bit so a following start edge is not missed
                    if (stop_q == LAST_STOP) begin
                        load      = 1'b1;
                        load_brk  = zero_q & ~maj;
                        load_ferr = ferr_q | ~maj;
                        state_d   = (zero_q & ~maj) ? S_BREAK : S_IDLE;
                        cnt_d     = '0;
                    end
                end else if (at_wrap) begin
                    stop_d = stop_q + 1'b1;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx       <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            ferr_q   <= 1'b0;
            zero_q   <= 1'b0;
            samp_a_q <= 1'b0;
            samp_b_q <= 1'b0;
        end else begin
            rx_meta  <= i_Rx;
            rx       <= rx_meta;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            ferr_q   <= ferr_d;
            zero_q   <= zero_d;
            samp_a_q <= samp_a_d;
            samp_b_q <= samp_b_d;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (load) begin
            o_data       <= load_brk ? '0 : shift_q;
            o_valid      <= 1'b1;
            o_parity_err <= par_err;
            o_frame_err  <= load_ferr;
            o_break      <= load_brk;
            o_overrun    <= o_valid & ~i_ready;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed/randomized bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) fed from a
// frame-building reference model; delivered words are collected and compared.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_line = 3'b111;
    logic [2:0] rdy = 3'b111;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int stop_start = 0;
    int rise0 = 0;
    logic v0_prev = 1'b0;

    logic [7:0] d0; logic v0, pe0, fe0, br0, ov0;
    logic [6:0] d1; logic v1, pe1, fe1, br1, ov1;
    logic [7:0] d2; logic v2, pe2, fe2, br2, ov2;

    logic [12:0] q0[$];
    logic [12:0] q1[$];
    logic [12:0] q2[$];

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk_50M(clk), .rst_n(rst_n), .i_Rx(rx_line[0]), .i_ready(rdy[0]), .o_data(d0),
        .o_valid(v0), .o_parity_err(pe0), .o_frame_err(fe0), .o_break(br0), .o_overrun(ov0));

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk_50M(clk), .rst_n(rst_n), .i_Rx(rx_line[1]), .i_ready(rdy[1]), .o_data(d1),
        .o_valid(v1), .o_parity_err(pe1), .o_frame_err(fe1), .o_break(br1), .o_overrun(ov1));

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk_50M(clk), .rst_n(rst_n), .i_Rx(rx_line[2]), .i_ready(rdy[2]), .o_data(d2),
        .o_valid(v2), .o_parity_err(pe2), .o_frame_err(fe2), .o_break(br2), .o_overrun(ov2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [12:0] mk(input logic ov, input logic br, input logic fe,
                                       input logic pe, input logic [8:0] d);
        return {ov, br, fe, pe, d};
    endfunction

    // Each accepted word (valid & ready at the sampling point) is one delivery
    always @(negedge clk) begin
        if (v0 && rdy[0]) q0.push_back(mk(ov0, br0, fe0, pe0, {1'b0, d0}));
        if (v1 && rdy[1]) q1.push_back(mk(ov1, br1, fe1, pe1, {2'b0, d1}));
        if (v2 && rdy[2]) q2.push_back(mk(ov2, br2, fe2, pe2, {1'b0, d2}));
        if (v0 && !v0_prev) rise0 = cyc;
        v0_prev = v0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    function automatic int qsize(input int ch);
        if (ch == 0) return q0.size();
        if (ch == 1) return q1.size();
        return q2.size();
    endfunction

    task automatic pop_check(input int ch, input string tag, input logic [12:0] exp);
        logic [12:0] w;
        int sz;
        sz = qsize(ch);
        check({tag, "_present"}, 32'(sz != 0), 32'd1);
        if (sz != 0) begin
            if (ch == 0) w = q0.pop_front();
            else if (ch == 1) w = q1.pop_front();
            else w = q2.pop_front();
            check(tag, 32'(w), 32'(exp));
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bits; flags from line rules
    task automatic build(input logic [8:0] data, input int nd, input int par, input int nstop,
                         input bit flip, input bit bad2, output logic [15:0] bits,
                         output int n, output logic perr, output logic ferr);
        int ones;
        logic p;
        bits = '1;
        n = 0;
        ones = 0;
        perr = 1'b0;
        ferr = 1'b0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < nd; i++) begin
            bits[n] = data[i];
            ones += int'(data[i]);
            n++;
        end
        if (par != 0) begin
            p = (par == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
            if (flip) p = ~p;
            bits[n] = p;
            n++;
            perr = (par == 1) ? ((ones + int'(p)) % 2 != 1) : ((ones + int'(p)) % 2 != 0);
        end
        for (int s = 0; s < nstop; s++) begin
            bits[n] = !(bad2 && s == 1);
            ferr |= !bits[n];
            n++;
        end
    endtask

    task automatic drive(input int ch, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_line[ch] = bits[i];
            if (i == n - 1) stop_start = cyc;
            tick(16);
        end
    endtask

    task automatic send_word(input int ch, input logic [8:0] data, input int nd, input int par,
                             input int nstop, input bit flip, input bit bad2, input string tag);
        logic [15:0] bits;
        int n;
        logic pe, fe;
        build(data, nd, par, nstop, flip, bad2, bits, n, pe, fe);
        drive(ch, bits, n);
        rx_line[ch] = 1'b1;
        tick(40);
        pop_check(ch, tag, mk(1'b0, 1'b0, fe, pe, data));
        check({tag, "_single"}, 32'(qsize(ch)), 32'd0);
    endtask

    initial begin
        logic [15:0] bits;
        int n;
        logic pe, fe;
        logic [8:0] rd;
        bit fl;

        tick(3);
        check("rst_valid", 32'({v0, v1, v2}), 32'd0);
        check("rst_data0", 32'(d0), 32'd0);
        check("rst_flags0", 32'({pe0, fe0, br0, ov0}), 32'd0);
        rst_n = 1'b1;
        tick(4);

        // 8N1 0xA5 with delivery latency inside the stop bit
        send_word(0, 9'h0A5, 8, 0, 1, 1'b0, 1'b0, "a5");
        check("a5_latency", 32'((rise0 - stop_start) >= 9 && (rise0 - stop_start) <= 15), 32'd1);
        for (int k = 0; k < 4; k++) begin
            rd = 9'($urandom_range(0, 255));
            send_word(0, rd, 8, 0, 1, 1'b0, 1'b0, "rand8n1");
        end

        // 7E1: good parity, then flipped parity, then random
        send_word(1, 9'h041, 7, 2, 1, 1'b0, 1'b0, "p41_ok");
        send_word(1, 9'h041, 7, 2, 1, 1'b1, 1'b0, "p41_bad");
        for (int k = 0; k < 4; k++) begin
            rd = 9'($urandom_range(0, 127));
            fl = 1'($urandom_range(0, 1));
            send_word(1, rd, 7, 2, 1, fl, 1'b0, "rand7e1");
        end

        // 8N2: second stop bit low, then clean frame
        send_word(2, 9'h03C, 8, 0, 2, 1'b0, 1'b1, "stop2_bad");
        send_word(2, 9'h03D, 8, 0, 2, 1'b0, 1'b0, "stop2_ok");

        // Start glitch must not produce a word
        rx_line[0] = 1'b0;
        tick(5);
        rx_line[0] = 1'b1;
        tick(160);
        check("glitch_none", 32'(qsize(0)), 32'd0);
        send_word(0, 9'h055, 8, 0, 1, 1'b0, 1'b0, "after_glitch");

        // Overrun: back-to-back frames, consumer not ready
        rdy[0] = 1'b0;
        build(9'h011, 8, 0, 1, 1'b0, 1'b0, bits, n, pe, fe);
        drive(0, bits, n);
        build(9'h022, 8, 0, 1, 1'b0, 1'b0, bits, n, pe, fe);
        drive(0, bits, n);
        tick(32);
        check("ovr_valid", 32'(v0), 32'd1);
        check("ovr_data", 32'(d0), 32'h22);
        check("ovr_flag", 32'(ov0), 32'd1);
        check("ovr_err", 32'({pe0, fe0, br0}), 32'd0);
        rdy[0] = 1'b1;
        tick(1);
        check("ovr_accept", 32'(v0), 32'd0);
        check("ovr_hold", 32'({ov0, d0}), 32'h122);
        q0.delete();

        // Break: line low 30 bit-times, released, then a clean byte
        rx_line[0] = 1'b0;
        tick(30 * 16);
        rx_line[0] = 1'b1;
        tick(32);
        pop_check(0, "break", mk(1'b0, 1'b1, 1'b1, 1'b0, 9'h000));
        check("break_single", 32'(qsize(0)), 32'd0);
        send_word(0, 9'h07E, 8, 0, 1, 1'b0, 1'b0, "after_break");

        // Asynchronous reset in the middle of a byte with a word pending
        rdy[0] = 1'b0;
        build(9'h05A, 8, 0, 1, 1'b0, 1'b0, bits, n, pe, fe);
        drive(0, bits, n);
        tick(16);
        check("pre_rst_valid", 32'({v0, d0}), 32'h15A);
        build(9'h0C3, 8, 0, 1, 1'b0, 1'b0, bits, n, pe, fe);
        drive(0, bits, 5);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(v0), 32'd0);
        check("midrst_data", 32'(d0), 32'd0);
        check("midrst_flags", 32'({pe0, fe0, br0, ov0}), 32'd0);
        rx_line[0] = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised next-generation UART receiver for the serial-protocols FPGA designs.
- Configurable data width, parity and stop bits; majority-of-3 mid-bit sampling; parity, framing and break detection.
- Holding register with valid/ready handshake and overrun flagging.
- Sits between the board Rx pin and any byte consumer (FIFO, command parser) in the clk_50M domain.

Parameters:
- CLKS_PER_BIT, 434: clk_50M cycles per bit (115200 baud); legal >= 8.
- DATA_BITS, 8: data bits per frame; legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal 1 or 2.

Ports:
- clk_50M  in  1  50 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_Rx  in  1  serial line, asynchronous, idle high.
- i_ready  in  1  consumer accepts the held word when high with o_valid.
- o_data  out  DATA_BITS  received data, LSB = first bit on the line.
- o_valid  out  1  held word is valid.
- o_parity_err  out  1  parity mismatch for the held word (always 0 if PARITY = 0).
- o_frame_err  out  1  any stop bit sampled 0 for the held word.
- o_break  out  1  held word is a break condition.
- o_overrun  out  1  held word replaced an unaccepted word.

Behaviour:
- Reset (async assert, sync release): both synchronizer flops = 1; state IDLE; counters 0; all outputs 0.
- Clocking and synchronizer: one clock only. i_Rx passes through a 2-flop synchronizer; rx is the second flop's output.
- Bit timer:
  - Counter runs 0..CLKS_PER_BIT-1 per bit.
  - Let H = CLKS_PER_BIT/2 (integer). rx is sampled at counts H-1, H and H+1.
  - Bit value = majority of the 3 samples, decided at count H+1.
  - Counter wraps to 0 at CLKS_PER_BIT-1 and advances to the next bit.
- IDLE:
  - counter = 0.
  - rx == 0 moves to START; counter starts from 0 on the following cycle.
- START:
  - Majority 1 at H+1: false start, return to IDLE.
  - Otherwise complete the bit period, then go to DATA.
- DATA:
  - DATA_BITS bits, shifted LSB first.
  - Go to PARITY if PARITY != 0, else to STOP.
- PARITY:
  - One bit. Error if XOR(data, parity bit) != 1 (odd) or != 0 (even).
- STOP:
  - STOP_BITS bits. Frame error if any stop bit majority is 0.
  - On the last stop bit, at its decision point (H+1), load the output word and go directly to IDLE, or to BREAK_WAIT on break. The remaining half period is not waited, so back-to-back frames are caught.
- Break:
  - Condition: start, all data, parity and all stop bits sampled 0.
  - Word loaded with o_break = 1, o_frame_err = 1, o_data = 0.
  - BREAK_WAIT holds until rx == 1, then goes to IDLE.
- Output load:
  - Word is registered one cycle after the decision sample.
  - Total latency from the final stop-bit mid-point on i_Rx is 2 sync cycles + 1 decision offset + 1 cycle.
  - Load sets o_valid = 1.
- Handshake:
  - o_valid & i_ready clears o_valid on the next edge.
  - o_data and the flags hold their value until the next load.
- Overrun:
  - If a load occurs while o_valid = 1 and i_ready = 0, the new word overwrites the old one and o_overrun = 1.
  - Any load with no pending unaccepted word sets o_overrun = 0.
- Simultaneous accept and load: the old word is accepted, the new word is loaded, o_valid stays 1, o_overrun = 0.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.
- Widths: counter width $clog2(CLKS_PER_BIT); bit index width $clog2(DATA_BITS+1).

Test Plan (CLKS_PER_BIT = 16 unless stated):
- 8N1, send 0xA5, i_ready held 1 -> single o_valid pulse, o_data = 0xA5, all error flags 0, o_valid one cycle after the stop decision point.
- DATA_BITS = 7, PARITY = 2, send 0x41 with correct parity bit, then the same with the parity bit flipped -> first word o_parity_err = 0; second o_data = 0x41, o_parity_err = 1.
- STOP_BITS = 2, second stop bit driven 0 while sending 0x3C -> o_data = 0x3C, o_frame_err = 1, o_break = 0; next 0x3D received cleanly.
- Start glitch of 5 clocks low, then 0x55 sent 10 bit-times later -> no word from the glitch; 0x55 received with o_overrun = 0.
- i_ready = 0, send 0x11 then 0x22 back-to-back with no idle gap -> o_valid stays 1, o_data = 0x22, o_overrun = 1. Raise i_ready -> o_valid drops next cycle.
- Line held low for 30 bit-times, then released, then 0x7E sent -> one word with o_break = 1, o_frame_err = 1, o_data = 0; then 0x7E with all flags 0. Assert rst_n = 0 mid-byte -> all outputs 0 asynchronously.
